jesd204b_rx_link_ctrl: RTL

- Sequences the 4-lane GTY receive path of the JESD204B subclass-1 RX interface: GT reset, comma alignment, code group synchronization (CGS), initial lane alignment sequence (ILAS) and entry to data phase.
- Drives SYNC~ toward the ADC, synchronized to a local multiframe clock (LMFC) that SYSREF phases.
- Runs in the rxusrclk2 domain and presents per-lane 32-bit user data qualified by a link-up valid.

---
 rtl/jesd204b_pkg.sv | 23 ++
 rtl/jesd204b_lane_mon.sv | 83 ++++++++
 rtl/jesd204b_rx_link_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jesd204b_pkg.sv
// Shared types and constants for the JESD204B RX link controller.
package jesd204b_pkg;

   // Link state encodings, also exported on o_state.
   typedef enum logic [2:0] {
      GT_RST  = 3'd0,
      GT_WAIT = 3'd1,
      CGS     = 3'd2,
      ILAS    = 3'd3,
      DATA    = 3'd4,
      RESYNC  = 3'd5
   } link_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;

   // LMFC period in user-clock cycles (4 octets per cycle per lane).
   function automatic int lmfc_period(input int f, input int k);
      return (f * k) / 4;
   endfunction

endpackage

// File: rtl/jesd204b_lane_mon.sv
// Per-lane monitor: K28.5 run/sync, /R/ and /A/ detection, error counting.
module jesd204b_lane_mon
   import jesd204b_pkg::*;
#(
   parameter int ILAS_MF   = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic        i_cgs,
   input  logic        i_ilas,
   input  logic        i_aligned,
   input  logic [31:0] i_data,
   input  logic [3:0]  i_charisk,
   input  logic [3:0]  i_err,
   output logic        o_sync,
   output logic        o_a_done,
   output logic        o_r_bad,
   output logic        o_err_hit
);
   localparam int AW = $clog2(ILAS_MF + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam logic [AW-1:0] A_MAX = AW'(ILAS_MF);
   localparam logic [AW-1:0] A_PRE = AW'(ILAS_MF - 1);
   localparam logic [EW-1:0] E_MAX = EW'(ERR_LIMIT);
   localparam logic [EW-1:0] E_PRE = EW'(ERR_LIMIT - 1);

   logic [1:0]    run_q;
   logic          sync_q;
   logic [AW-1:0] acnt_q;
   logic [EW-1:0] ecnt_q;
   logic          k28_5, a_hit, r_upper, err_any;

   // Character classification of the current 4-byte word.
   always_comb begin
      k28_5   = (&i_charisk) && (i_data == {4{K28_5}});
      a_hit   = i_charisk[3] && (i_data[31:24] == K28_3);
      err_any = |i_err;
      r_upper = 1'b0;
      for (int b = 1; b < 4; b++)
         if (i_charisk[b] && (i_data[8*b +: 8] == K28_0)) r_upper = 1'b1;
   end

   // Sync needs four consecutive all-K28.5 words; a bad word restarts the run.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q  <= '0;
         sync_q <= 1'b0;
      end else if (i_clr) begin
         run_q  <= '0;
         sync_q <= 1'b0;
      end else if (i_cgs && !sync_q) begin
         if (k28_5 && i_aligned) begin
            if (run_q == 2'd3) sync_q <= 1'b1;
            else               run_q  <= run_q + 2'd1;
         end else begin
            run_q <= '0;
         end
      end
   end

   // /A/ count during ILAS and saturating error count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acnt_q <= '0;
         ecnt_q <= '0;
      end else if (i_clr) begin
         acnt_q <= '0;
         ecnt_q <= '0;
      end else begin
         if (i_ilas && a_hit && (acnt_q != A_MAX)) acnt_q <= acnt_q + 1'b1;
         if (err_any && (ecnt_q != E_MAX))         ecnt_q <= ecnt_q + 1'b1;
      end
   end

   // Look-ahead flags so the FSM acts on the same cycle the count completes.
   assign o_sync    = sync_q;
   assign o_a_done  = (acnt_q == A_MAX) || ((acnt_q == A_PRE) && i_ilas && a_hit);
   assign o_r_bad   = i_ilas && r_upper;
   assign o_err_hit = (ecnt_q == E_MAX) || ((ecnt_q == E_PRE) && err_any);

endmodule

// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B subclass-1 RX link controller: GT reset, CGS, ILAS, data phase.
module jesd204b_rx_link_ctrl
   import jesd204b_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int FRAME_SIZE = 1,
   parameter int FMLC_NUM   = 8,
   parameter int ILAS_MF    = 4,
   parameter int ERR_LIMIT  = 3,
   parameter int GT_RST_CYC = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_sysref,
   input  logic                  i_gt_reset_rx_done,
   input  logic [LANES-1:0]      i_byteisaligned,
   input  logic [LANES*32-1:0]   i_rx_data,
   input  logic [LANES*4-1:0]    i_rx_charisk,
   input  logic [LANES*4-1:0]    i_rx_err,
   output logic                  o_gt_reset_all,
   output logic                  o_rx8b10ben,
   output logic                  o_commaalign_en,
   output logic                  o_nsync,
   output logic                  o_link_up,
   output logic [LANES*32-1:0]   o_rx_data,
   output logic                  o_rx_valid,
   output logic [2:0]            o_state,
   output logic                  o_lmfc_edge
);
   localparam int P  = lmfc_period(FRAME_SIZE, FMLC_NUM);
   localparam int LW = (P > 1) ? $clog2(P) : 1;
   localparam int GW = $clog2(GT_RST_CYC + 1);
   localparam logic [LW-1:0] L_LAST = LW'(P - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GT_RST_CYC - 1);

   link_state_e       state_q, state_d;
   logic [GW-1:0]     gcnt_q;
   logic [LW-1:0]     lmfc_q, lmfc_nat, lmfc_d;
   logic              sysref_q, lmfc_edge_q;
   logic              gt_reset_all_q, rx8b10ben_q, comma_q, nsync_q, link_up_q, rx_valid_q;
   logic [LANES*32-1:0] rx_data_q;
   logic [LANES-1:0]  sync_w, a_done_w, r_bad_w, err_hit_w;
   logic              lane_clr, in_cgs, in_ilas;

   assign lane_clr = !(state_q inside {CGS, ILAS, DATA});
   assign in_cgs   = (state_q == CGS);
   assign in_ilas  = (state_q == ILAS);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      jesd204b_lane_mon #(.ILAS_MF(ILAS_MF), .ERR_LIMIT(ERR_LIMIT)) u_mon (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_clr     (lane_clr),
         .i_cgs     (in_cgs),
         .i_ilas    (in_ilas),
         .i_aligned (i_byteisaligned[g]),
         .i_data    (i_rx_data[32*g +: 32]),
         .i_charisk (i_rx_charisk[4*g +: 4]),
         .i_err     (i_rx_err[4*g +: 4]),
         .o_sync    (sync_w[g]),
         .o_a_done  (a_done_w[g]),
         .o_r_bad   (r_bad_w[g]),
         .o_err_hit (err_hit_w[g])
      );
   end

   // Natural LMFC advance; the nsync release decision uses this, not the SYSREF reload.
   assign lmfc_nat = (lmfc_q == L_LAST) ? '0 : lmfc_q + 1'b1;
   assign lmfc_d   = (i_sysref && !sysref_q) ? '0 : lmfc_nat;

   // LMFC counter with SYSREF phase alignment; edge flag tracks counter == 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sysref_q    <= 1'b0;
         lmfc_q      <= '0;
         lmfc_edge_q <= 1'b0;
      end else begin
         sysref_q    <= i_sysref;
         lmfc_q      <= lmfc_d;
         lmfc_edge_q <= (lmfc_d == '0);
      end
   end

   // Next-state decode; errors take priority over ILAS completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GT_RST:  if (gcnt_q == G_LAST) state_d = GT_WAIT;
         GT_WAIT: if (i_gt_reset_rx_done) state_d = CGS;
         CGS:     if ((&sync_w) && (lmfc_nat == '0)) state_d = ILAS;
         ILAS: begin
            if ((|err_hit_w) || (|r_bad_w) || !(&i_byteisaligned)) state_d = RESYNC;
            else if (&a_done_w)                                     state_d = DATA;
         end
         DATA:    if ((|err_hit_w) || !(&i_byteisaligned)) state_d = RESYNC;
         RESYNC:  state_d = CGS;
         default: state_d = GT_RST;
      endcase
      if ((state_q inside {CGS, ILAS, DATA, RESYNC}) && !i_gt_reset_rx_done)
         state_d = GT_RST;
   end

   // State register, GT reset timer and registered control outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= GT_RST;
         gcnt_q         <= '0;
         gt_reset_all_q <= 1'b1;
         rx8b10ben_q    <= 1'b0;
         comma_q        <= 1'b0;
         nsync_q        <= 1'b0;
         link_up_q      <= 1'b0;
         rx_valid_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         gcnt_q         <= ((state_q == GT_RST) && (state_d == GT_RST)) ? gcnt_q + 1'b1 : '0;
         gt_reset_all_q <= (state_d == GT_RST);
         rx8b10ben_q    <= (state_d != GT_RST);
         comma_q        <= (state_d == CGS);
         nsync_q        <= (state_d == ILAS) || (state_d == DATA);
         link_up_q      <= (state_d == DATA);
         rx_valid_q     <= (state_d == DATA);
      end
   end

   // One-cycle data pipeline; o_rx_valid qualifies it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rx_data_q <= '0;
      else          rx_data_q <= i_rx_data;
   end

   assign o_gt_reset_all  = gt_reset_all_q;
   assign o_rx8b10ben     = rx8b10ben_q;
   assign o_commaalign_en = comma_q;
   assign o_nsync         = nsync_q;
   assign o_link_up       = link_up_q;
   assign o_rx_valid      = rx_valid_q;
   assign o_rx_data       = rx_data_q;
   assign o_state         = state_q;
   assign o_lmfc_edge     = lmfc_edge_q;

endmodule
